// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle for the ID/EX operand stage: decode inputs, forwarding sources,
// hazard-unit controls and the ALU-facing outputs. The stage itself uses the slave modport.
interface id_ex_operand_stage_if #(
  parameter int BITS     = 32,
  parameter int REG_BITS = 5
);
  logic                stall;
  logic                flush;
  logic                id_valid;
  logic [BITS-1:0]     id_rs_data;
  logic [BITS-1:0]     id_rt_data;
  logic [BITS-1:0]     id_imm;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic [REG_BITS-1:0] id_rd;
  logic [1:0]          id_alu_op;
  logic [5:0]          id_funct;
  logic                id_alu_src;
  logic                id_reg_dst;
  logic                id_reg_write;
  logic                exmem_reg_write;
  logic [REG_BITS-1:0] exmem_rd;
  logic [BITS-1:0]     exmem_result;
  logic                memwb_reg_write;
  logic [REG_BITS-1:0] memwb_rd;
  logic [BITS-1:0]     memwb_result;

  logic [BITS-1:0]     op1;
  logic [BITS-1:0]     op2;
  logic [3:0]          alu_control;
  logic [BITS-1:0]     store_data;
  logic                ex_valid;
  logic                ex_reg_write;
  logic [REG_BITS-1:0] ex_dest;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_alu_op, id_funct, id_alu_src,
           id_reg_dst, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  op1, op2, alu_control, store_data, ex_valid, ex_reg_write,
           ex_dest, fwd_a, fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_alu_op, id_funct, id_alu_src,
           id_reg_dst, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output op1, op2, alu_control, store_data, ex_valid, ex_reg_write,
           ex_dest, fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with registered ALU-control decode and EX/MEM, MEM/WB operand
// forwarding. Optional feature macro: FORWARDING_EN (undefined = regfile data only, fwd_* = 00).
module id_ex_operand_stage #(
  parameter int BITS     = 32,
  parameter int REG_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_ex_operand_stage_if.slave   bus
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Handshake: no back-pressure. ex_valid qualifies the stage contents; stall holds every
  // register, flush (higher priority) loads an all-zero bubble, otherwise decode is loaded.

  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [3:0] code;
    code = ALU_ADD;
    if (alu_op == 2'b01) begin
      code = ALU_SUB;
    end else if (alu_op == 2'b10) begin
      case (funct)
        6'b100000: code = ALU_ADD;
        6'b100010: code = ALU_SUB;
        6'b100100: code = ALU_AND;
        6'b100101: code = ALU_OR;
        6'b101010: code = ALU_SLT;
        default:   code = ALU_ADD;
      endcase
    end
    return code;
  endfunction

  logic                valid_q,     valid_d;
  logic                reg_write_q, reg_write_d;
  logic [REG_BITS-1:0] dest_q,      dest_d;
  logic [3:0]          alu_ctrl_q,  alu_ctrl_d;
  logic [REG_BITS-1:0] rs_q,        rs_d;
  logic [REG_BITS-1:0] rt_q,        rt_d;
  logic [BITS-1:0]     rs_data_q,   rs_data_d;
  logic [BITS-1:0]     rt_data_q,   rt_data_d;
  logic [BITS-1:0]     imm_q,       imm_d;
  logic                alu_src_q,   alu_src_d;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    dest_d      = dest_q;
    alu_ctrl_d  = alu_ctrl_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      dest_d      = '0;
      alu_ctrl_d  = 4'b0000;
      rs_d        = '0;
      rt_d        = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = bus.id_valid;
      // An empty decode slot must never write back, whatever its control bits say.
      reg_write_d = bus.id_valid & bus.id_reg_write;
      dest_d      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      alu_ctrl_d  = alu_decode(bus.id_alu_op, bus.id_funct);
      rs_d        = bus.id_rs;
      rt_d        = bus.id_rt;
      rs_data_d   = bus.id_rs_data;
      rt_data_d   = bus.id_rt_data;
      imm_d       = bus.id_imm;
      alu_src_d   = bus.id_alu_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      dest_q      <= '0;
      alu_ctrl_q  <= 4'b0000;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      dest_q      <= dest_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
    end
  end

  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic [BITS-1:0] rs_val;
  logic [BITS-1:0] rt_val;

`ifdef FORWARDING_EN
  // EX/MEM is the younger producer, so it wins; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_select(input logic [REG_BITS-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == src)) begin
      sel = 2'b10;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_select(rs_q);
    fwd_b_sel = fwd_select(rt_q);
    rs_val    = rs_data_q;
    rt_val    = rt_data_q;
    if (fwd_a_sel == 2'b10)      rs_val = bus.exmem_result;
    else if (fwd_a_sel == 2'b01) rs_val = bus.memwb_result;
    if (fwd_b_sel == 2'b10)      rt_val = bus.exmem_result;
    else if (fwd_b_sel == 2'b01) rt_val = bus.memwb_result;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                               bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result,
                               rs_q, rt_q};
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
  assign rs_val    = rs_data_q;
  assign rt_val    = rt_data_q;
`endif

  assign bus.op1          = rs_val;
  assign bus.store_data   = rt_val;
  assign bus.op2          = alu_src_q ? imm_q : rt_val;
  assign bus.alu_control  = alu_ctrl_q;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_reg_write = reg_write_q;
  assign bus.ex_dest      = dest_q;
  assign bus.fwd_a        = fwd_a_sel;
  assign bus.fwd_b        = fwd_b_sel;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised bench for id_ex_operand_stage: a stage-record model plus directed literal
// checks for reset, decode, forwarding priority, the register-0 guard, immediates, stall and flush.
module tb_id_ex_operand_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_operand_stage_if #(.BITS(32), .REG_BITS(5)) bus ();

  id_ex_operand_stage #(.BITS(32), .REG_BITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // What the stage holds, as a plain record of the decoded instruction.
  logic        m_valid, m_rw, m_src;
  logic [4:0]  m_dest, m_rs, m_rt;
  logic [3:0]  m_ctrl;
  logic [31:0] m_rsd, m_rtd, m_imm;

  function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic [5:0] funct);
    if (aop == 2'd1) return 4'd6;
    if (aop != 2'd2) return 4'd2;
    if (funct == 6'd32) return 4'd2;
    if (funct == 6'd34) return 4'd6;
    if (funct == 6'd36) return 4'd0;
    if (funct == 6'd37) return 4'd1;
    if (funct == 6'd42) return 4'd7;
    return 4'd2;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_src = 0; m_dest = 0; m_rs = 0; m_rt = 0;
    m_ctrl = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      model_clear();
    end else if (!bus.stall) begin
      m_valid = bus.id_valid;
      m_rw    = bus.id_valid && bus.id_reg_write;
      m_dest  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      m_ctrl  = ref_alu(bus.id_alu_op, bus.id_funct);
      m_rs    = bus.id_rs;
      m_rt    = bus.id_rt;
      m_rsd   = bus.id_rs_data;
      m_rtd   = bus.id_rt_data;
      m_imm   = bus.id_imm;
      m_src   = bus.id_alu_src;
    end
  end

  // {select, value} for a source register given the live forwarding sources.
  function automatic logic [33:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (FWD && idx != 0 && bus.exmem_reg_write && bus.exmem_rd == idx)
      return {2'b10, bus.exmem_result};
    if (FWD && idx != 0 && bus.memwb_reg_write && bus.memwb_rd == idx)
      return {2'b01, bus.memwb_result};
    return {2'b00, rf};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] a, b;
    a = ref_fwd(m_rs, m_rsd);
    b = ref_fwd(m_rt, m_rtd);
    check("m_op1",        bus.op1, a[31:0]);
    check("m_store_data", bus.store_data, b[31:0]);
    check("m_op2",        bus.op2, m_src ? m_imm : b[31:0]);
    check("m_fwd_a",      {30'd0, bus.fwd_a}, {30'd0, a[33:32]});
    check("m_fwd_b",      {30'd0, bus.fwd_b}, {30'd0, b[33:32]});
    check("m_alu_ctrl",   {28'd0, bus.alu_control}, {28'd0, m_ctrl});
    check("m_ex_valid",   {31'd0, bus.ex_valid}, {31'd0, m_valid});
    check("m_reg_write",  {31'd0, bus.ex_reg_write}, {31'd0, m_rw});
    check("m_ex_dest",    {27'd0, bus.ex_dest}, {27'd0, m_dest});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, rt, rd,
                           input logic [31:0] rsd, rtd, imm,
                           input logic [1:0] aop, input logic [5:0] funct,
                           input logic src, dst, rw);
    bus.id_valid = v;      bus.id_rs = rs;          bus.id_rt = rt;   bus.id_rd = rd;
    bus.id_rs_data = rsd;  bus.id_rt_data = rtd;    bus.id_imm = imm;
    bus.id_alu_op = aop;   bus.id_funct = funct;    bus.id_alu_src = src;
    bus.id_reg_dst = dst;  bus.id_reg_write = rw;
  endtask

  task automatic set_sources(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                             input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
  endtask

  task automatic randomize_inputs();
    logic v;
    v = 1'($urandom_range(0, 3) != 0);
    set_instr(v, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63))
                                           : 6'(32 + 2 * $urandom_range(0, 5)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              v & 1'($urandom_range(0, 1)));
    set_sources(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    bus.stall = ($urandom_range(0, 4) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.stall = 0;
    bus.flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_sources(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_alu_ctrl", {28'd0, bus.alu_control}, 32'd0);
    check("rst_op1",      bus.op1, 32'd0);
    check("rst_fwd_a",    {30'd0, bus.fwd_a}, 32'd0);
    #2 rst_n = 1'b1;

    // Mid-cycle reset with a real instruction loaded.
    set_instr(1, 1, 2, 3, 32'h1234, 32'h5678, 0, 2'd1, 0, 0, 1, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_ex_valid",  {31'd0, bus.ex_valid}, 32'd0);
    check("async_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check("async_ex_dest",   {27'd0, bus.ex_dest}, 32'd0);
    check("async_op1",       bus.op1, 32'd0);
    #1 rst_n = 1'b1;

    // R-type subtract, no forwarding matches.
    set_instr(1, 1, 2, 3, 32'd7, 32'd3, 0, 2'd2, 6'b100010, 0, 1, 1);
    step();
    @(negedge clk);
    check("rtype_op1",      bus.op1, 32'd7);
    check("rtype_op2",      bus.op2, 32'd3);
    check("rtype_alu_ctrl", {28'd0, bus.alu_control}, 32'h6);
    check("rtype_ex_dest",  {27'd0, bus.ex_dest}, 32'd3);
    check("rtype_ex_valid", {31'd0, bus.ex_valid}, 32'd1);

    // Forwarding priority: both stages target r5.
    set_instr(1, 5, 5, 9, 32'hA, 32'hB, 0, 2'd2, 6'b100000, 0, 1, 1);
    step();
    bus.stall = 1;
    set_sources(1, 5, 32'h11, 1, 5, 32'h22);
    #1;
    check("prio_op1",   bus.op1, FWD ? 32'h11 : 32'hA);
    check("prio_op2",   bus.op2, FWD ? 32'h11 : 32'hB);
    check("prio_fwd_a", {30'd0, bus.fwd_a}, FWD ? 32'd2 : 32'd0);
    check("prio_fwd_b", {30'd0, bus.fwd_b}, FWD ? 32'd2 : 32'd0);
    bus.exmem_reg_write = 0;
    #1;
    check("memwb_op1",   bus.op1, FWD ? 32'h22 : 32'hA);
    check("memwb_op2",   bus.op2, FWD ? 32'h22 : 32'hB);
    check("memwb_fwd_a", {30'd0, bus.fwd_a}, FWD ? 32'd1 : 32'd0);
    check("memwb_fwd_b", {30'd0, bus.fwd_b}, FWD ? 32'd1 : 32'd0);
    bus.stall = 0;

    // Register 0 is never forwarded.
    set_instr(1, 0, 1, 2, 32'h55, 32'h66, 0, 2'd0, 0, 0, 0, 1);
    set_sources(1, 0, 32'h77, 1, 0, 32'h88);
    step();
    check("r0_fwd_a", {30'd0, bus.fwd_a}, 32'd0);
    check("r0_op1",   bus.op1, 32'h55);

    // Immediate operand with rt forwarded for store data.
    set_instr(1, 1, 6, 0, 32'h1, 32'h99, 32'hFFFF_FFFC, 2'd0, 0, 1, 0, 0);
    set_sources(1, 6, 32'h40, 0, 0, 0);
    step();
    check("imm_op2",   bus.op2, 32'hFFFF_FFFC);
    check("imm_store", bus.store_data, FWD ? 32'h40 : 32'h99);
    check("imm_fwd_b", {30'd0, bus.fwd_b}, FWD ? 32'd2 : 32'd0);
    check("imm_alu",   {28'd0, bus.alu_control}, 32'h2);

    // Stall held three cycles, then stall+flush together.
    set_sources(0, 0, 0, 0, 0, 0);
    set_instr(1, 1, 2, 7, 32'h3, 32'h4, 0, 2'd2, 6'b100101, 0, 1, 1);
    step();
    bus.stall = 1;
    set_instr(1, 3, 4, 12, 32'hDEAD, 32'hBEEF, 0, 2'd1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ex_dest",  {27'd0, bus.ex_dest}, 32'd7);
      check("stall_alu_ctrl", {28'd0, bus.alu_control}, 32'h1);
      check("stall_op1",      bus.op1, 32'h3);
    end
    bus.flush = 1;
    step();
    check("flush_ex_valid",  {31'd0, bus.ex_valid}, 32'd0);
    check("flush_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check("flush_alu_ctrl",  {28'd0, bus.alu_control}, 32'd0);
    bus.flush = 0;
    bus.stall = 0;

    // Random traffic, with an occasional mid-cycle reset pulse.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      randomize_inputs();
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
